cache_control: RTL and testbench

//  Control FSM for the 2-way set-associative, write-back L1 cache in the LC-3b pipeline.

---
 rtl/cache_control.sv | 106 ++++++++++
 tb/tb_cache_control.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// cache_control: control FSM for the 2-way set-associative write-back L1 cache.
// Sweeps valid/dirty/LRU arrays after reset, serves 0-wait hits, and sequences writeback/allocate over pmem.
`timescale 1ns/1ps
module cache_control #(
    parameter int INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  hit0,
    input  logic                  hit1,
    input  logic                  lru_out,
    input  logic                  dirty_lru,
    input  logic                  pmem_resp,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic                  pmem_addr_sel,
    output logic                  data_sel,
    output logic [1:0]            load_data,
    output logic [1:0]            load_tag,
    output logic [1:0]            load_valid,
    output logic                  valid_in,
    output logic [1:0]            load_dirty,
    output logic                  dirty_in,
    output logic                  lru_write,
    output logic                  lru_in,
    output logic                  init_active,
    output logic [INDEX_BITS-1:0] init_index
);
    typedef enum logic [1:0] {INIT, IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t state, state_next;
    logic [INDEX_BITS-1:0] cnt;
    logic req, hit;
    logic [1:0] hit_mask, lru_mask;
    assign req = mem_read | mem_write;
    assign hit = hit0 | hit1;
    // a double hit resolves to way0
    assign hit_mask = hit0 ? 2'b01 : 2'b10;
    assign lru_mask = lru_out ? 2'b10 : 2'b01;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= INIT;
            cnt <= '0;
        end else begin
            state <= state_next;
            cnt <= (state == INIT) ? cnt + 1'b1 : '0;
        end
    always_comb begin
        state_next = state;
        mem_resp = 1'b0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_addr_sel = 1'b0;
        data_sel = 1'b0;
        load_data = 2'b00;
        load_tag = 2'b00;
        load_valid = 2'b00;
        valid_in = 1'b0;
        load_dirty = 2'b00;
        dirty_in = 1'b0;
        lru_write = 1'b0;
        lru_in = 1'b0;
        init_active = 1'b0;
        init_index = '0;
        case (state)
            INIT: begin
                init_active = 1'b1;
                init_index = cnt;
                load_valid = 2'b11;
                load_dirty = 2'b11;
                lru_write = 1'b1;
                state_next = (cnt == '1) ? IDLE : INIT;
            end
            IDLE:
                if (req && hit) begin
                    mem_resp = 1'b1;
                    lru_write = 1'b1;
                    lru_in = hit0;
                    load_data = mem_write ? hit_mask : 2'b00;
                    load_dirty = mem_write ? hit_mask : 2'b00;
                    dirty_in = mem_write;
                end else if (req)
                    state_next = dirty_lru ? WRITEBACK : ALLOCATE;
            WRITEBACK: begin
                pmem_write = 1'b1;
                pmem_addr_sel = 1'b1;
                state_next = pmem_resp ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                // the line is installed even if the CPU has dropped its request
                if (pmem_resp) begin
                    load_data = lru_mask;
                    load_tag = lru_mask;
                    load_valid = lru_mask;
                    load_dirty = lru_mask;
                    data_sel = 1'b1;
                    valid_in = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: randomized self-checking bench for cache_control against a transaction-level model.
`timescale 1ns/1ps
module tb_cache_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_read = 1'b0, mem_write = 1'b0, hit0 = 1'b0, hit1 = 1'b0;
    logic lru_out = 1'b0, dirty_lru = 1'b0, pmem_resp = 1'b0;
    logic mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, valid_in, dirty_in;
    logic lru_write, lru_in, init_active;
    logic [1:0] load_data, load_tag, load_valid, load_dirty;
    logic [2:0] init_index;
    logic [17:0] outs;
    int total = 0;
    int bad = 0;

    cache_control #(.INDEX_BITS(3)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .hit0(hit0), .hit1(hit1), .lru_out(lru_out), .dirty_lru(dirty_lru),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .data_sel(data_sel),
        .load_data(load_data), .load_tag(load_tag), .load_valid(load_valid),
        .valid_in(valid_in), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .lru_write(lru_write), .lru_in(lru_in), .init_active(init_active),
        .init_index(init_index)
    );

    always #5 clk = ~clk;

    assign outs = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_sel, load_data, load_tag,
                   load_valid, valid_in, load_dirty, dirty_in, lru_write, lru_in, init_active};

    function automatic logic [17:0] vec(input logic mr, pr, pw, pas, ds, input logic [1:0] ld, lt, lv,
                                        input logic vi, input logic [1:0] ldy, input logic di, lw, li, ia);
        return {mr, pr, pw, pas, ds, ld, lt, lv, vi, ldy, di, lw, li, ia};
    endfunction

    // IDLE-cycle expectation: a request that hits completes now and marks the other way LRU
    function automatic logic [17:0] exp_hit(input logic rd, wr, h0, h1);
        int way;
        logic [1:0] m;
        if (!(rd | wr) || !(h0 | h1)) return '0;
        way = h0 ? 0 : 1;
        m = (way == 0) ? 2'b01 : 2'b10;
        return vec(1, 0, 0, 0, 0, wr ? m : 2'b00, 2'b00, 2'b00, 0, wr ? m : 2'b00, wr, 1, way == 0, 0);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic init_sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            {mem_read, mem_write, hit0, hit1, pmem_resp, lru_out, dirty_lru} = 7'($urandom);
            @(negedge clk);
            total++;
            if (outs !== vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 2'b11, 0, 1, 0, 1) || init_index !== 3'(i)) begin
                bad++;
                $display("FAIL %s_init[%0d]: got outs=%b idx=%0d want outs=%b idx=%0d", tag, i, outs, init_index,
                         vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 2'b11, 0, 1, 0, 1), i);
            end
            next_cycle();
        end
        {mem_read, mem_write, hit0, hit1, pmem_resp} = 5'b10010;
        @(negedge clk);
        total++;
        if (outs !== exp_hit(1, 0, 0, 1)) begin
            bad++;
            $display("FAIL %s_idle_after_init: got %b want %b", tag, outs, exp_hit(1, 0, 0, 1));
        end
        next_cycle();
        {mem_read, mem_write, hit0, hit1} = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if (init_active !== 1'b1 || init_index !== 3'd0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got ia=%b idx=%0d pr=%b pw=%b want 1 0 0 0", init_active, init_index, pmem_read, pmem_write);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        init_sweep("reset");
    endtask

    task automatic test_hits(input int n);
        logic [17:0] e;
        for (int k = 0; k < n; k++) begin
            {mem_read, mem_write, hit0, hit1, lru_out, dirty_lru, pmem_resp} = 7'($urandom);
            if ((mem_read | mem_write) && !(hit0 | hit1)) hit1 = 1'b1;
            e = exp_hit(mem_read, mem_write, hit0, hit1);
            @(negedge clk);
            total++;
            if (outs !== e) begin
                bad++;
                $display("FAIL hit[%0d] rd=%b wr=%b h0=%b h1=%b: got %b want %b", k, mem_read, mem_write, hit0, hit1, outs, e);
            end
            next_cycle();
        end
        {mem_read, mem_write, hit0, hit1, pmem_resp} = 5'b0;
    endtask

    task automatic test_miss(input int n);
        logic wr, rd, dirty, lru, drop;
        int wl, rl;
        logic [1:0] m;
        logic [17:0] e;
        for (int k = 0; k < n; k++) begin
            wr = 1'($urandom);
            rd = wr ? 1'($urandom) : 1'b1;
            dirty = 1'($urandom);
            lru = 1'($urandom);
            drop = ($urandom_range(0, 3) == 0);
            wl = $urandom_range(1, 6);
            rl = $urandom_range(1, 6);
            m = lru ? 2'b10 : 2'b01;
            {mem_read, mem_write, hit0, hit1, lru_out, dirty_lru, pmem_resp} = {rd, wr, 2'b00, lru, dirty, 1'b0};
            @(negedge clk);
            total++;
            if (outs !== '0) begin
                bad++;
                $display("FAIL miss[%0d]_idle: got %b want %b", k, outs, 18'd0);
            end
            next_cycle();
            if (drop) {mem_read, mem_write} = 2'b00;
            for (int i = 0; dirty && i < wl; i++) begin
                pmem_resp = (i == wl - 1);
                @(negedge clk);
                total++;
                if (outs !== vec(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0)) begin
                    bad++;
                    $display("FAIL miss[%0d]_writeback[%0d]: got %b want pmem_write+addr_sel only", k, i, outs);
                end
                next_cycle();
            end
            for (int i = 0; i < rl; i++) begin
                pmem_resp = (i == rl - 1);
                e = pmem_resp ? vec(0, 1, 0, 0, 1, m, m, m, 1, m, 0, 0, 0, 0)
                              : vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0);
                @(negedge clk);
                total++;
                if (outs !== e) begin
                    bad++;
                    $display("FAIL miss[%0d]_allocate[%0d] lru=%b: got %b want %b", k, i, lru, outs, e);
                end
                next_cycle();
            end
            {pmem_resp, hit0, hit1} = {1'b0, !lru, lru};
            e = exp_hit(mem_read, mem_write, hit0, hit1);
            @(negedge clk);
            total++;
            if (outs !== e) begin
                bad++;
                $display("FAIL miss[%0d]_rehit drop=%b: got %b want %b", k, drop, outs, e);
            end
            next_cycle();
            {mem_read, mem_write, hit0, hit1} = 4'b0000;
        end
    endtask

    task automatic test_reset_alloc();
        {mem_read, mem_write, hit0, hit1, lru_out, dirty_lru, pmem_resp} = {2'b10, 2'b00, 1'($urandom), 2'b00};
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (pmem_read !== 1'b1 || pmem_write !== 1'b0) begin
                bad++;
                $display("FAIL ralloc_pre[%0d]: got pr=%b pw=%b want 1 0", i, pmem_read, pmem_write);
            end
            if (i == 0) next_cycle();
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (pmem_read !== 1'b0 || init_active !== 1'b1 || init_index !== 3'd0) begin
            bad++;
            $display("FAIL ralloc_async: got pr=%b ia=%b idx=%0d want 0 1 0", pmem_read, init_active, init_index);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        init_sweep("ralloc");
    endtask

    initial begin
        test_reset();
        test_hits(60);
        test_miss(25);
        test_hits(20);
        test_reset_alloc();
        test_miss(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
